// File: rtl/udt_rx_depacketizer_if.sv
// udt_rx_depacketizer_if: 64-bit AXI-Stream link used for the UDP input and both output streams
interface udt_rx_depacketizer_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  modport master(output tvalid, tdata, tkeep, tlast, input tready);
  modport slave(input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/udt_rx_depacketizer.sv
// udt_rx_depacketizer: strips UDT headers off UDP payloads, routes data/control packets, drops and counts bad ones
module udt_rx_depacketizer #(
  parameter logic [31:0] LOCAL_SOCK_ID = 32'h0000_0001,
  parameter bit          CHECK_SOCK    = 1'b1,
  parameter int          CNT_W         = 32
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  udt_rx_depacketizer_if.slave  udp_rx,
  udt_rx_depacketizer_if.master rx_axis,
  output logic [30:0]           rx_seq,
  output logic [31:0]           rx_msgno,
  output logic [31:0]           rx_tstamp,
  output logic                  ctrl_hdr_valid,
  input  logic                  ctrl_hdr_ready,
  output logic [14:0]           ctrl_type,
  output logic [15:0]           ctrl_ext,
  output logic [31:0]           ctrl_info,
  output logic [31:0]           ctrl_tstamp,
  output logic                  ctrl_has_body,
  udt_rx_depacketizer_if.master ctrl_axis,
  output logic [CNT_W-1:0]      drop_runt_cnt,
  output logic [CNT_W-1:0]      drop_sock_cnt,
  output logic [CNT_W-1:0]      data_pkt_cnt,
  output logic [CNT_W-1:0]      ctrl_pkt_cnt
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHDR, CBODY, DROP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_w0, r_w1;
  logic        r_rx_v, r_cx_v, r_tlast;
  logic [63:0] r_tdata;
  logic [7:0]  r_tkeep;
  logic        w_rdy, w_acc, w_full, w_sock_bad;
  logic        w_ld_data, w_ld_ctrl, w_ld_beat;
  logic        w_inc_runt, w_inc_sock, w_inc_data, w_inc_ctrl;
  logic [31:0] w_ts, w_sock;

  function automatic logic [31:0] be32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign w_ts       = be32(udp_rx.tdata[31:0]);
  assign w_sock     = be32(udp_rx.tdata[63:32]);
  assign w_full     = udp_rx.tkeep == 8'hFF;
  assign w_sock_bad = CHECK_SOCK && w_sock != LOCAL_SOCK_ID;
  // HDR1 waits for every output of the previous packet to drain so sideband never changes under it
  assign w_rdy = !core_rst & ((r_state == HDR0 || r_state == DROP) ? 1'b1 :
                              r_state == HDR1  ? !r_rx_v & !r_cx_v & !ctrl_hdr_valid :
                              r_state == DATA  ? !r_rx_v | rx_axis.tready :
                              r_state == CBODY ? !r_cx_v | ctrl_axis.tready : 1'b0);
  assign w_acc         = udp_rx.tvalid & w_rdy;
  assign udp_rx.tready = w_rdy;

  always_comb begin
    w_next     = r_state;
    w_ld_data  = 1'b0;
    w_ld_ctrl  = 1'b0;
    w_ld_beat  = 1'b0;
    w_inc_runt = 1'b0;
    w_inc_sock = 1'b0;
    w_inc_data = 1'b0;
    w_inc_ctrl = 1'b0;
    case (r_state)
      HDR0: begin
        w_inc_runt = w_acc & (udp_rx.tlast | !w_full);
        w_next     = (w_acc & !w_inc_runt) ? HDR1 : HDR0;
      end
      HDR1: if (w_acc) begin
        w_inc_runt = !w_full | (!w_sock_bad & !r_w0[31] & udp_rx.tlast);
        w_inc_sock = w_full & w_sock_bad;
        w_ld_data  = w_full & !w_sock_bad & !r_w0[31] & !udp_rx.tlast;
        w_ld_ctrl  = w_full & !w_sock_bad & r_w0[31];
        w_next     = w_ld_data ? DATA : w_ld_ctrl ? CHDR : udp_rx.tlast ? HDR0 : DROP;
      end
      DATA: begin
        w_ld_beat  = w_acc;
        w_inc_data = w_acc & udp_rx.tlast;
        w_next     = w_inc_data ? HDR0 : DATA;
      end
      CHDR: begin
        w_inc_ctrl = ctrl_hdr_valid & ctrl_hdr_ready;
        w_next     = w_inc_ctrl ? (ctrl_has_body ? CBODY : HDR0) : CHDR;
      end
      CBODY: begin
        w_ld_beat = w_acc;
        w_next    = (w_acc & udp_rx.tlast) ? HDR0 : CBODY;
      end
      DROP: w_next = (w_acc & udp_rx.tlast) ? HDR0 : DROP;
      default: w_next = HDR0;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_state        <= HDR0;
      r_w0           <= '0;
      r_w1           <= '0;
      r_rx_v         <= 1'b0;
      r_cx_v         <= 1'b0;
      r_tdata        <= '0;
      r_tkeep        <= '0;
      r_tlast        <= 1'b0;
      rx_seq         <= '0;
      rx_msgno       <= '0;
      rx_tstamp      <= '0;
      ctrl_hdr_valid <= 1'b0;
      ctrl_type      <= '0;
      ctrl_ext       <= '0;
      ctrl_info      <= '0;
      ctrl_tstamp    <= '0;
      ctrl_has_body  <= 1'b0;
      drop_runt_cnt  <= '0;
      drop_sock_cnt  <= '0;
      data_pkt_cnt   <= '0;
      ctrl_pkt_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == HDR0 && w_acc) begin
        r_w0 <= be32(udp_rx.tdata[31:0]);
        r_w1 <= be32(udp_rx.tdata[63:32]);
      end
      if (w_ld_data) begin
        rx_seq    <= r_w0[30:0];
        rx_msgno  <= r_w1;
        rx_tstamp <= w_ts;
      end
      if (w_ld_ctrl) begin
        ctrl_hdr_valid <= 1'b1;
        ctrl_type      <= r_w0[30:16];
        ctrl_ext       <= r_w0[15:0];
        ctrl_info      <= r_w1;
        ctrl_tstamp    <= w_ts;
        ctrl_has_body  <= !udp_rx.tlast;
      end else if (ctrl_hdr_ready) ctrl_hdr_valid <= 1'b0;
      if (w_ld_beat) begin
        r_tdata <= udp_rx.tdata;
        r_tkeep <= udp_rx.tkeep;
        r_tlast <= udp_rx.tlast;
      end
      r_rx_v        <= (w_ld_beat & r_state == DATA) | (r_rx_v & !rx_axis.tready);
      r_cx_v        <= (w_ld_beat & r_state == CBODY) | (r_cx_v & !ctrl_axis.tready);
      drop_runt_cnt <= drop_runt_cnt + CNT_W'(w_inc_runt & ~&drop_runt_cnt);
      drop_sock_cnt <= drop_sock_cnt + CNT_W'(w_inc_sock & ~&drop_sock_cnt);
      data_pkt_cnt  <= data_pkt_cnt + CNT_W'(w_inc_data & ~&data_pkt_cnt);
      ctrl_pkt_cnt  <= ctrl_pkt_cnt + CNT_W'(w_inc_ctrl & ~&ctrl_pkt_cnt);
    end
  end

  assign rx_axis.tvalid   = r_rx_v;
  assign rx_axis.tdata    = r_tdata;
  assign rx_axis.tkeep    = r_tkeep;
  assign rx_axis.tlast    = r_tlast;
  assign ctrl_axis.tvalid = r_cx_v;
  assign ctrl_axis.tdata  = r_tdata;
  assign ctrl_axis.tkeep  = r_tkeep;
  assign ctrl_axis.tlast  = r_tlast;
endmodule

// File: tb/tb_udt_rx_depacketizer.sv
// tb_udt_rx_depacketizer: table of packet vectors plus hand sequences, outputs checked against scoreboard queues
module tb_udt_rx_depacketizer;
  logic core_clk = 1'b0;
  logic core_rst = 1'b1;
  always #5 core_clk = ~core_clk;

  udt_rx_depacketizer_if udp();
  udt_rx_depacketizer_if rx();
  udt_rx_depacketizer_if cx();
  logic [30:0] rx_seq;
  logic [31:0] rx_msgno, rx_tstamp, ctrl_info, ctrl_tstamp;
  logic        ctrl_hdr_valid, ctrl_hdr_ready, ctrl_has_body;
  logic [14:0] ctrl_type;
  logic [15:0] ctrl_ext;
  logic [31:0] drop_runt_cnt, drop_sock_cnt, data_pkt_cnt, ctrl_pkt_cnt;

  udt_rx_depacketizer dut (
    .core_clk(core_clk), .core_rst(core_rst), .udp_rx(udp), .rx_axis(rx),
    .rx_seq(rx_seq), .rx_msgno(rx_msgno), .rx_tstamp(rx_tstamp),
    .ctrl_hdr_valid(ctrl_hdr_valid), .ctrl_hdr_ready(ctrl_hdr_ready),
    .ctrl_type(ctrl_type), .ctrl_ext(ctrl_ext), .ctrl_info(ctrl_info),
    .ctrl_tstamp(ctrl_tstamp), .ctrl_has_body(ctrl_has_body), .ctrl_axis(cx),
    .drop_runt_cnt(drop_runt_cnt), .drop_sock_cnt(drop_sock_cnt),
    .data_pkt_cnt(data_pkt_cnt), .ctrl_pkt_cnt(ctrl_pkt_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [30:0] seq;
    logic [31:0] msg, ts;
  } beat_t;
  typedef struct {
    logic [14:0] typ;
    logic [15:0] ext;
    logic [31:0] info, ts;
    logic        body;
  } hdr_t;
  typedef struct {
    logic [31:0] w0, w1, ts, sock;
    int          hdr_beats, npay;
    logic [7:0]  lkeep;
    int          d_runt, d_sock, d_data, d_ctrl;
  } vec_t;

  beat_t rxq[$];
  beat_t cq[$];
  hdr_t  hq[$];
  int total = 0, bad = 0;
  int e_runt = 0, e_sock = 0, e_data = 0, e_ctrl = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bs(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // called at posedge+1; returns at posedge+1 after the beat is taken
  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int t = 0;
    udp.tvalid = 1'b1;
    udp.tdata  = d;
    udp.tkeep  = k;
    udp.tlast  = l;
    @(negedge core_clk);
    while (!udp.tready && t < 200) begin
      @(negedge core_clk);
      t++;
    end
    chk("beat_accept_timeout", 64'(t < 200), 64'd1);
    @(posedge core_clk);
    #1;
    udp.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v);
    beat_t b;
    hdr_t  h;
    e_runt += v.d_runt;
    e_sock += v.d_sock;
    e_data += v.d_data;
    e_ctrl += v.d_ctrl;
    if (v.d_ctrl != 0) begin
      h.typ  = v.w0[30:16];
      h.ext  = v.w0[15:0];
      h.info = v.w1;
      h.ts   = v.ts;
      h.body = v.npay > 0;
      hq.push_back(h);
    end
    beat({bs(v.w1), bs(v.w0)}, 8'hFF, v.hdr_beats == 1);
    if (v.hdr_beats == 1) return;
    beat({bs(v.sock), bs(v.ts)}, 8'hFF, v.npay == 0);
    for (int i = 0; i < v.npay; i++) begin
      b.d   = {$urandom, $urandom};
      b.l   = i == v.npay - 1;
      b.k   = b.l ? v.lkeep : 8'hFF;
      b.seq = v.w0[30:0];
      b.msg = v.w1;
      b.ts  = v.ts;
      if (v.d_data != 0) rxq.push_back(b);
      else if (v.d_ctrl != 0) cq.push_back(b);
      beat(b.d, b.k, b.l);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((rxq.size() + cq.size() + hq.size()) != 0 && t < 3000) begin
      @(negedge core_clk);
      t++;
    end
    chk("drain_timeout", 64'(t < 3000), 64'd1);
    repeat (3) @(posedge core_clk);
    #1;
  endtask

  task automatic chk_cnt();
    chk("drop_runt_cnt", drop_runt_cnt, e_runt);
    chk("drop_sock_cnt", drop_sock_cnt, e_sock);
    chk("data_pkt_cnt", data_pkt_cnt, e_data);
    chk("ctrl_pkt_cnt", ctrl_pkt_cnt, e_ctrl);
  endtask

  always @(posedge core_clk) begin
    #1;
    rx.tready = rdy_mode == 2 ? 1'b0 : rdy_mode == 1 ? 1'($urandom_range(1)) : 1'b1;
    cx.tready = rdy_mode == 1 ? 1'($urandom_range(1)) : 1'b1;
  end

  logic rx_pend = 1'b0, cx_pend = 1'b0;
  logic [63:0] rx_pd, cx_pd;
  always @(negedge core_clk) begin
    beat_t e;
    hdr_t  h;
    if (core_rst) begin
      rx_pend = 1'b0;
      cx_pend = 1'b0;
    end else begin
      if (rx_pend) begin
        chk("rx_hold_valid", rx.tvalid, 1);
        chk("rx_hold_data", rx.tdata, rx_pd);
      end
      if (cx_pend) begin
        chk("cx_hold_valid", cx.tvalid, 1);
        chk("cx_hold_data", cx.tdata, cx_pd);
      end
      if (rx.tvalid && rx.tready) begin
        if (rxq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got beat %h, expected none", rx.tdata);
        end else begin
          e = rxq.pop_front();
          chk("rx_tdata", rx.tdata, e.d);
          chk("rx_tkeep", rx.tkeep, e.k);
          chk("rx_tlast", rx.tlast, e.l);
          chk("rx_seq", rx_seq, e.seq);
          chk("rx_msgno", rx_msgno, e.msg);
          chk("rx_tstamp", rx_tstamp, e.ts);
        end
      end
      if (cx.tvalid && cx.tready) begin
        if (cq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cx_unexpected: got beat %h, expected none", cx.tdata);
        end else begin
          e = cq.pop_front();
          chk("cx_tdata", cx.tdata, e.d);
          chk("cx_tkeep", cx.tkeep, e.k);
          chk("cx_tlast", cx.tlast, e.l);
        end
      end
      if (ctrl_hdr_valid && ctrl_hdr_ready) begin
        if (hq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL hdr_unexpected: got type %h, expected none", ctrl_type);
        end else begin
          h = hq.pop_front();
          chk("ctrl_type", ctrl_type, h.typ);
          chk("ctrl_ext", ctrl_ext, h.ext);
          chk("ctrl_info", ctrl_info, h.info);
          chk("ctrl_tstamp", ctrl_tstamp, h.ts);
          chk("ctrl_has_body", ctrl_has_body, h.body);
        end
      end
      rx_pend = rx.tvalid && !rx.tready;
      rx_pd   = rx.tdata;
      cx_pend = cx.tvalid && !cx.tready;
      cx_pd   = cx.tdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[9];
    vec_t  v;
    hdr_t  h;
    beat_t b;
    udp.tvalid = 1'b0;
    udp.tdata  = '0;
    udp.tkeep  = '0;
    udp.tlast  = 1'b0;
    ctrl_hdr_ready = 1'b1;
    tbl[0] = '{32'h0000_0005, 32'hC000_0001, 32'h10, 32'h1, 2, 3, 8'h0F, 0, 0, 1, 0};
    tbl[1] = '{32'h0000_0007, 32'h0, 32'h0, 32'h1, 1, 0, 8'hFF, 1, 0, 0, 0};
    tbl[2] = '{32'h0000_0008, 32'h1, 32'h20, 32'h1, 2, 0, 8'hFF, 1, 0, 0, 0};
    tbl[3] = '{32'h0000_0009, 32'h8000_0002, 32'h30, 32'h1, 2, 1, 8'hFF, 0, 0, 1, 0};
    tbl[4] = '{32'h0000_000A, 32'h3, 32'h40, 32'h99, 2, 4, 8'hFF, 0, 1, 0, 0};
    tbl[5] = '{32'h8005_1234, 32'hAABB_CCDD, 32'h50, 32'h1, 2, 0, 8'hFF, 0, 0, 0, 1};
    tbl[6] = '{32'h8006_0000, 32'h11, 32'h60, 32'h1, 2, 2, 8'h03, 0, 0, 0, 1};
    tbl[7] = '{32'h8002_0000, 32'h7, 32'h70, 32'h2, 2, 0, 8'hFF, 0, 1, 0, 0};
    tbl[8] = '{32'h7FFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h1, 2, 1, 8'h01, 0, 0, 1, 0};

    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_udp_tready", udp.tready, 0);
    chk("rst_rx_tvalid", rx.tvalid, 0);
    chk("rst_cx_tvalid", cx.tvalid, 0);
    chk("rst_hdr_valid", ctrl_hdr_valid, 0);
    chk_cnt();
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    @(negedge core_clk);
    chk("tready_after_rst", udp.tready, 1);
    @(posedge core_clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      send_pkt(tbl[i]);
      drain();
      chk_cnt();
    end

    ctrl_hdr_ready = 1'b0;
    h.typ = 15'h2; h.ext = 16'h0; h.info = 32'h7; h.ts = 32'h80; h.body = 1'b1;
    hq.push_back(h);
    beat({bs(32'h7), bs(32'h8002_0000)}, 8'hFF, 1'b0);
    beat({bs(32'h1), bs(32'h80)}, 8'hFF, 1'b0);
    b.d = 64'h0123_4567_89AB_CDEF; b.k = 8'hFF; b.l = 1'b1; b.seq = '0; b.msg = '0; b.ts = '0;
    cq.push_back(b);
    udp.tvalid = 1'b1; udp.tdata = b.d; udp.tkeep = b.k; udp.tlast = b.l;
    repeat (5) begin
      @(negedge core_clk);
      chk("chdr_stall_tready", udp.tready, 0);
      chk("chdr_hdr_valid", ctrl_hdr_valid, 1);
      @(posedge core_clk);
      #1;
    end
    ctrl_hdr_ready = 1'b1;
    beat(b.d, b.k, b.l);
    e_ctrl++;
    drain();
    chk_cnt();
    chk("ack_ctrl_type", ctrl_type, 15'h2);

    rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      v.w0 = 32'(i) + 32'h100; v.w1 = $urandom; v.ts = $urandom; v.sock = 32'h1;
      v.hdr_beats = 2; v.npay = $urandom_range(1, 4); v.lkeep = 8'hFF >> $urandom_range(7);
      v.d_runt = 0; v.d_sock = 0; v.d_data = 1; v.d_ctrl = 0;
      send_pkt(v);
    end
    drain();
    rdy_mode = 0;
    chk_cnt();

    rdy_mode = 2;
    @(posedge core_clk);
    #1;
    beat({bs(32'h0), bs(32'h0000_0003)}, 8'hFF, 1'b0);
    beat({bs(32'h1), bs(32'h90)}, 8'hFF, 1'b0);
    beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
    @(negedge core_clk);
    chk("pre_rst_rx_tvalid", rx.tvalid, 1);
    @(posedge core_clk);
    #1;
    core_rst = 1'b1;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("midrst_rx_tvalid", rx.tvalid, 0);
    chk("midrst_cx_tvalid", cx.tvalid, 0);
    chk("midrst_hdr_valid", ctrl_hdr_valid, 0);
    chk("midrst_udp_tready", udp.tready, 0);
    chk("midrst_rx_seq", rx_seq, 0);
    e_runt = 0; e_sock = 0; e_data = 0; e_ctrl = 0;
    chk_cnt();
    rdy_mode = 0;
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    @(negedge core_clk);
    chk("postrst_udp_tready", udp.tready, 1);
    @(posedge core_clk);
    #1;
    send_pkt(tbl[0]);
    drain();
    chk_cnt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
